gray_codec_pipe: RTL and testbench

GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

---
 rtl/gray_codec_pipe.sv | 152 +++++++++++++++
 tb/tb_gray_codec_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe
//   Elastic STAGES-deep pipeline that converts each beat between Gray and
//   binary code. Mode travels with the beat:
//     in_mode = 0 : Gray-to-binary. The work is split MSB-first into slices
//                   of C = ceil(DW/STAGES) bits, one slice per stage.
//     in_mode = 1 : binary-to-Gray, done entirely in stage 0. Later stages
//                   pass the word through unchanged.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears every stage)
//   in_valid   upstream beat present
//   in_ready   a beat is accepted this cycle (stage-0 load condition)
//   in_mode    conversion mode, sampled with the beat
//   in_data    DW-bit operand
//   out_valid  result beat present (last stage valid)
//   out_ready  downstream accepts the result
//   out_mode   mode carried with the result
//   out_data   DW-bit converted result
//   busy       any stage holds a valid beat
module gray_codec_pipe #(
  parameter int DW     = 32,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_mode,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  // Guard against division by zero before the elaboration check fires.
  localparam int SAFE_ST = (STAGES < 1) ? 1 : STAGES;
  // Bits resolved per stage in Gray-to-binary mode.
  localparam int C = (DW + SAFE_ST - 1) / SAFE_ST;

  if (DW < 2 || DW > 64) begin : g_bad_dw
    $fatal(1, "gray_codec_pipe: DW=%0d outside 2..64", DW);
  end
  if (STAGES < 1 || STAGES > DW) begin : g_bad_stages
    $fatal(1, "gray_codec_pipe: STAGES=%0d outside 1..DW", STAGES);
  end

  // Binary-to-Gray: each output bit is the XOR of the bit and its upper
  // neighbour; the MSB is passed unchanged.
  function automatic logic [DW-1:0] bin2gray(input logic [DW-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Resolve Gray bits hi..lo into binary, MSB first. Bits above hi are
  // already binary, so each bit XORs its Gray value with the resolved bit
  // directly above it. The MSB of the word needs no work.
  function automatic logic [DW-1:0] gray2bin_slice(input logic [DW-1:0] w,
                                                    input int unsigned hi,
                                                    input int unsigned lo);
    logic [DW-1:0] r;
    int unsigned   idx;
    r = w;
    for (int unsigned j = 0; j < DW; j++) begin
      idx = DW - 1 - j;
      if (idx <= hi && idx >= lo && idx < DW - 1) begin
        r[idx] = r[idx + 1] ^ w[idx];
      end
    end
    return r;
  endfunction

  // Stage registers
  logic [STAGES-1:0] sv;           // valid
  logic [STAGES-1:0] sm;           // mode
  logic [DW-1:0]     sd [STAGES];  // data word

  // Per-stage source (predecessor) and the word each stage would capture.
  logic [STAGES-1:0] srcv;
  logic [STAGES-1:0] srcm;
  logic [DW-1:0]     srcd [STAGES];
  logic [DW-1:0]     nd   [STAGES];

  // ld[k]: stage k captures this cycle. ld[STAGES] is the downstream
  // acceptance, so the ready chain ripples back from out_ready.
  logic [STAGES:0]   ld;

  always_comb begin
    ld[STAGES] = out_ready;
    for (int unsigned k = STAGES; k > 0; k--) begin
      ld[k-1] = ~sv[k-1] | ld[k];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_src
      assign srcv[s] = in_valid;
      assign srcm[s] = in_mode;
      assign srcd[s] = in_data;
    end else begin : g_src
      assign srcv[s] = sv[s-1];
      assign srcm[s] = sm[s-1];
      assign srcd[s] = sd[s-1];
    end

    if (s * C >= DW) begin : g_pass
      // No Gray slice left for this stage; both modes pass through.
      assign nd[s] = srcd[s];
    end else begin : g_slice
      localparam int unsigned HI = DW - 1 - s * C;
      localparam int unsigned LO = (DW > (s + 1) * C) ? DW - (s + 1) * C : 0;
      if (s == 0) begin : g_first
        assign nd[s] = srcm[s] ? bin2gray(srcd[s])
                               : gray2bin_slice(srcd[s], HI, LO);
      end else begin : g_later
        assign nd[s] = srcm[s] ? srcd[s]
                               : gray2bin_slice(srcd[s], HI, LO);
      end
    end
  end

  // A loading stage always takes its predecessor's valid (so an empty
  // predecessor clears it); mode and data only move with a real beat,
  // which keeps a stalled or drained output word stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv <= '0;
      sm <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        sd[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          sv[k] <= srcv[k];
          if (srcv[k]) begin
            sm[k] <= srcm[k];
            sd[k] <= nd[k];
          end
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = sv[STAGES-1];
  assign out_mode  = sm[STAGES-1];
  assign out_data  = sd[STAGES-1];
  assign busy      = |sv;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Testbench for gray_codec_pipe. Five instances cover DW=8 with STAGES 4, 3
// and 8, and DW=32 with STAGES 1 and 32. A behavioural model predicts each
// accepted beat's result; one monitor process checks every output transfer
// in order and checks that stalled outputs hold still.
module tb_gray_codec_pipe;

  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv  [N];
  logic        ir  [N];
  logic        im  [N];
  logic [31:0] id  [N];
  logic        ov  [N];
  logic        orr [N];
  logic        om  [N];
  logic        bsy [N];
  logic [7:0]  od8  [3];
  logic [31:0] od32 [2];

  gray_codec_pipe #(.DW(8), .STAGES(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_mode(im[0]),
    .in_data(id[0][7:0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_mode(om[0]),
    .out_data(od8[0]), .busy(bsy[0]));
  gray_codec_pipe #(.DW(8), .STAGES(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_mode(im[1]),
    .in_data(id[1][7:0]), .out_valid(ov[1]), .out_ready(orr[1]), .out_mode(om[1]),
    .out_data(od8[1]), .busy(bsy[1]));
  gray_codec_pipe #(.DW(8), .STAGES(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_mode(im[2]),
    .in_data(id[2][7:0]), .out_valid(ov[2]), .out_ready(orr[2]), .out_mode(om[2]),
    .out_data(od8[2]), .busy(bsy[2]));
  gray_codec_pipe #(.DW(32), .STAGES(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_mode(im[3]),
    .in_data(id[3]), .out_valid(ov[3]), .out_ready(orr[3]), .out_mode(om[3]),
    .out_data(od32[0]), .busy(bsy[3]));
  gray_codec_pipe #(.DW(32), .STAGES(32)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .in_mode(im[4]),
    .in_data(id[4]), .out_valid(ov[4]), .out_ready(orr[4]), .out_mode(om[4]),
    .out_data(od32[1]), .busy(bsy[4]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int stages_of(input int k);
    case (k)
      0:       return 4;
      1:       return 3;
      2:       return 8;
      3:       return 1;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] get_od(input int k);
    case (k)
      0:       return {24'h0, od8[0]};
      1:       return {24'h0, od8[1]};
      2:       return {24'h0, od8[2]};
      3:       return od32[0];
      default: return od32[1];
    endcase
  endfunction

  // Reference conversion: binary bit i is the XOR of every Gray bit at or
  // above i; Gray is x XOR (x >> 1).
  function automatic logic [31:0] model(input int k, input logic mode, input logic [31:0] x);
    logic [31:0] mask, v, r;
    mask = (k < 3) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    v = x & mask;
    if (mode) begin
      r = v ^ (v >> 1);
    end else begin
      r = '0;
      for (int sh = 0; sh < 32; sh++) r ^= v >> sh;
    end
    return r & mask;
  endfunction

  // Expected results in acceptance order: {mode, data}
  logic [32:0] q [N][$];
  logic        held [N];
  logic [31:0] hd   [N];
  logic        hm   [N];

  // Monitor: inputs are driven at the falling edge; 2 ns later every
  // handshake that will complete at the next rising edge is visible.
  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        q[k].delete();
        held[k] = 1'b0;
      end else begin
        if (held[k]) begin
          chk($sformatf("dut%0d stall valid", k), 64'(ov[k]), 64'd1);
          chk($sformatf("dut%0d stall data", k), 64'(get_od(k)), 64'(hd[k]));
          chk($sformatf("dut%0d stall mode", k), 64'(om[k]), 64'(hm[k]));
        end
        if (ov[k] && orr[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("dut%0d unexpected beat", k), 64'd1, 64'd0);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("dut%0d data", k), 64'(get_od(k)), 64'(e[31:0]));
            chk($sformatf("dut%0d mode", k), 64'(om[k]), 64'(e[32]));
          end
        end
        held[k] = ov[k] && !orr[k];
        hd[k]   = get_od(k);
        hm[k]   = om[k];
        if (iv[k] && ir[k]) q[k].push_back({im[k], model(k, im[k], id[k])});
      end
    end
  end

  // One beat into an idle instance; checks latency and the literal result.
  task automatic send_one(input int k, input logic mode, input logic [31:0] data,
                          input logic [31:0] exp);
    int n;
    bit seen;
    @(negedge clk);
    iv[k]  = 1'b1;
    im[k]  = mode;
    id[k]  = data;
    orr[k] = 1'b1;
    #1;
    chk($sformatf("dut%0d idle in_ready", k), 64'(ir[k]), 64'd1);
    @(negedge clk);
    iv[k] = 1'b0;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= stages_of(k) + 4) begin
      #2;
      if (ov[k]) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk($sformatf("dut%0d latency", k), 64'(n), 64'(stages_of(k)));
    chk($sformatf("dut%0d directed data", k), 64'(get_od(k)), 64'(exp));
    chk($sformatf("dut%0d directed mode", k), 64'(om[k]), 64'(mode));
  endtask

  int idx1, idx2;
  int acc [N];
  int cnt [N];
  bit gap [N];
  bit idle;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0; im[k] = 1'b0; id[k] = '0; orr[k] = 1'b0;
    end
    // A beat offered during reset must not be taken.
    iv[0] = 1'b1;
    id[0] = 32'h5A;
    repeat (3) @(negedge clk);
    #2;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("dut%0d reset out_valid", k), 64'(ov[k]), 64'd0);
      chk($sformatf("dut%0d reset busy", k), 64'(bsy[k]), 64'd0);
      chk($sformatf("dut%0d reset in_ready", k), 64'(ir[k]), 64'd1);
      chk($sformatf("dut%0d reset out_data", k), 64'(get_od(k)), 64'd0);
      chk($sformatf("dut%0d reset out_mode", k), 64'(om[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    iv[0] = 1'b0;
    @(negedge clk);
    #2;
    chk("dut0 no beat taken in reset", 64'(bsy[0]), 64'd0);

    // Directed conversions
    send_one(0, 1'b0, 32'h0D, 32'h09);
    send_one(0, 1'b1, 32'hFF, 32'h80);
    send_one(0, 1'b1, 32'h09, 32'h0D);
    send_one(3, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
    send_one(3, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    send_one(4, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
    send_one(4, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);

    // Random traffic; dut1/dut2 sweep all 256 Gray codes then all 256 binaries.
    idx1 = 0;
    idx2 = 0;
    for (int cyc = 0; cyc < 8000 && (idx1 < 512 || idx2 < 512); cyc++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        orr[k] = ((cyc % 128) < 12) ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
      for (int k = 0; k < N; k += (k == 0) ? 3 : 1) begin
        iv[k] = ($urandom_range(0, 3) != 0);
        im[k] = 1'($urandom_range(0, 1));
        id[k] = $urandom;
      end
      iv[1] = (idx1 < 512) && ($urandom_range(0, 3) != 0);
      im[1] = (idx1 >= 256);
      id[1] = 32'(idx1 % 256);
      iv[2] = (idx2 < 512) && ($urandom_range(0, 3) != 0);
      im[2] = (idx2 >= 256);
      id[2] = 32'(idx2 % 256);
      #1;
      if (iv[1] && ir[1]) idx1++;
      if (iv[2] && ir[2]) idx2++;
    end
    chk("dut1 sweep complete", 64'(idx1), 64'd512);
    chk("dut2 sweep complete", 64'(idx2), 64'd512);

    // Drain everything
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b1;
    end
    idle = 1'b0;
    for (int c = 0; c < 100 && !idle; c++) begin
      @(negedge clk);
      #3;
      idle = 1'b1;
      for (int k = 0; k < N; k++) if (bsy[k]) idle = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      chk($sformatf("dut%0d drained busy", k), 64'(bsy[k]), 64'd0);
      chk($sformatf("dut%0d scoreboard empty", k), 64'(q[k].size()), 64'd0);
    end

    // Fill with out_ready low: exactly STAGES beats accepted.
    for (int k = 0; k < N; k++) acc[k] = 0;
    repeat (40) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        orr[k] = 1'b0; iv[k] = 1'b1;
        im[k] = 1'($urandom_range(0, 1)); id[k] = $urandom;
      end
      #1;
      for (int k = 0; k < N; k++) if (iv[k] && ir[k]) acc[k]++;
    end
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("dut%0d full accept count", k), 64'(acc[k]), 64'(stages_of(k)));
      chk($sformatf("dut%0d full in_ready", k), 64'(ir[k]), 64'd0);
      chk($sformatf("dut%0d full busy", k), 64'(bsy[k]), 64'd1);
    end
    // Release: beats leave one per cycle with no gap.
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b1; cnt[k] = 0; gap[k] = 1'b0;
    end
    for (int c = 0; c < 40; c++) begin
      #3;
      for (int k = 0; k < N; k++) begin
        if (ov[k]) begin
          if (cnt[k] != c) gap[k] = 1'b1;
          cnt[k]++;
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < N; k++) begin
      chk($sformatf("dut%0d drain count", k), 64'(cnt[k]), 64'(stages_of(k)));
      chk($sformatf("dut%0d drain gap", k), 64'(gap[k]), 64'd0);
    end

    // Reset with beats in flight
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      orr[k] = 1'b0; iv[k] = 1'b1; im[k] = 1'b0; id[k] = $urandom;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) iv[k] = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) chk($sformatf("dut%0d pre-reset busy", k), 64'(bsy[k]), 64'd1);
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("dut%0d async reset out_valid", k), 64'(ov[k]), 64'd0);
      chk($sformatf("dut%0d async reset busy", k), 64'(bsy[k]), 64'd0);
      chk($sformatf("dut%0d async reset out_data", k), 64'(get_od(k)), 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) orr[k] = 1'b1;
    send_one(0, 1'b0, 32'h0D, 32'h09);
    send_one(1, 1'b1, 32'hA5, 32'hF7);
    send_one(2, 1'b0, 32'hFF, 32'hAA);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
